// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning path and the
// downstream mode latch.
package btn_pkg;

  localparam int N_BTN_DEFAULT = 4;
  localparam int MODE_W        = 2;

  // Highest set bit wins (3 > 2 > 1 > 0); returns 0 for an all-zero vector.
  function automatic logic [MODE_W-1:0] prio_enc(input logic [N_BTN_DEFAULT-1:0] v);
    prio_enc = '0;
    for (int i = 0; i < N_BTN_DEFAULT; i++)
      if (v[i]) prio_enc = MODE_W'(i);
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bus: raw pins in, debounced level / pulses / mode request out.
interface btn_conditioner_if #(parameter int N_BTN = btn_pkg::N_BTN_DEFAULT);
  import btn_pkg::*;

  logic [N_BTN-1:0]  btn_raw;
  logic [N_BTN-1:0]  btn_level;
  logic [N_BTN-1:0]  btn_press;
  logic [N_BTN-1:0]  btn_release;
  logic              mode_req_valid;
  logic [MODE_W-1:0] mode_req;

  // Board / stimulus side: drives the pins, observes the conditioned outputs.
  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, mode_req_valid, mode_req
  );

  // Conditioner side.
  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, mode_req_valid, mode_req
  );
endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchronizer, stability counter, debounced level
// and registered press/release pulses.
module btn_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 1250000
) (
  input  logic clk_125,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rls,
  output logic press_next
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1, sync2;
  logic [CNT_W-1:0] cnt;
  logic             flip;
  logic             rls_next;

  // Level flips only once sync2 has disagreed for DEBOUNCE_CYCLES samples.
  assign flip       = (sync2 != level) && (cnt == CNT_MAX);
  assign press_next = flip & sync2;
  assign rls_next   = flip & ~sync2;

  // Synchronizer, counter, level and pulse registers.
  always_ff @(posedge clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rls   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      press <= press_next;
      rls   <= rls_next;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: N_BTN debounced channels plus a priority-encoded
// mode request registered alongside the press pulses.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 1250000
) (
  input  logic               clk_125,
  input  logic               rst_n,
  btn_conditioner_if.slave   bus
);

  logic [N_BTN-1:0]         press_next;
  logic [N_BTN_DEFAULT-1:0] press_enc_in;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clk_125    (clk_125),
      .rst_n      (rst_n),
      .raw        (bus.btn_raw[g]),
      .level      (bus.btn_level[g]),
      .press      (bus.btn_press[g]),
      .rls        (bus.btn_release[g]),
      .press_next (press_next[g])
    );
  end

  assign press_enc_in = N_BTN_DEFAULT'(press_next);

  // Mode request: valid with any press, index held between presses.
  always_ff @(posedge clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      bus.mode_req_valid <= 1'b0;
      bus.mode_req       <= '0;
    end else begin
      bus.mode_req_valid <= |press_next;
      if (|press_next) bus.mode_req <= prio_enc(press_enc_in);
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner with DEBOUNCE_CYCLES=4.
module tb_btn_conditioner;
  import btn_pkg::*;

  localparam int DEB = 4;

  logic clk_125 = 1'b0;
  logic rst_n   = 1'b0;

  btn_conditioner_if #(.N_BTN(4)) bus ();

  btn_conditioner #(.N_BTN(4), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk_125 (clk_125),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #4 clk_125 = ~clk_125;

  typedef struct packed {
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] rel;
    logic       valid;
    logic [1:0] req;
  } exp_t;

  typedef enum logic { OP_ROW, OP_RST } op_t;

  // One row: hold raw for n edges. If lvl differs from the current level,
  // the flip (with the given pulses) is expected after edge DEB+1 of the row.
  typedef struct {
    op_t        op;
    logic [3:0] raw;
    int         n;
    logic [3:0] lvl;
    logic [3:0] press;
    logic [3:0] rel;
    logic [1:0] req;
  } row_t;

  row_t tbl[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic [3:0] cur_level;
  logic [1:0] cur_req;

  function automatic exp_t sample();
    exp_t s;
    s.level = bus.btn_level;
    s.press = bus.btn_press;
    s.rel   = bus.btn_release;
    s.valid = bus.mode_req_valid;
    s.req   = bus.mode_req;
    return s;
  endfunction

  task automatic cmp(input string name, input exp_t got, input exp_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got lvl=%b prs=%b rel=%b vld=%b req=%0d, want lvl=%b prs=%b rel=%b vld=%b req=%0d",
               name, got.level, got.press, got.rel, got.valid, got.req,
               exp.level, exp.press, exp.rel, exp.valid, exp.req);
    end
  endtask

  task automatic add(input op_t op, input logic [3:0] raw, input int n, input logic [3:0] lvl,
                     input logic [3:0] press, input logic [3:0] rel, input logic [1:0] req);
    row_t r;
    r.op = op; r.raw = raw; r.n = n; r.lvl = lvl; r.press = press; r.rel = rel; r.req = req;
    tbl.push_back(r);
  endtask

  task automatic run_row(input int idx, input row_t r);
    exp_t e, got;
    logic chg;
    logic [1:0] req_after;
    chg       = (r.lvl != cur_level);
    req_after = (|r.press) ? r.req : cur_req;
    for (int k = 0; k < r.n; k++) begin
      bus.btn_raw = r.raw;
      e = '0;
      if (chg && k >= DEB + 1) begin
        e.level = r.lvl;
        e.req   = req_after;
        if (k == DEB + 1) begin
          e.press = r.press;
          e.rel   = r.rel;
          e.valid = |r.press;
        end
      end else begin
        e.level = cur_level;
        e.req   = cur_req;
      end
      sb.push_back(e);
      @(posedge clk_125);
      #1;
      got = sample();
      e   = sb.pop_front();
      cmp($sformatf("row%0d_edge%0d", idx, k), got, e);
    end
    cur_level = r.lvl;
    cur_req   = req_after;
  endtask

  // Reset pulse starting mid-cycle: outputs must clear before any edge.
  task automatic run_rst(input int idx);
    rst_n = 1'b0;
    #1;
    cmp($sformatf("row%0d_async_rst", idx), sample(), exp_t'(0));
    @(posedge clk_125);
    #1;
    cmp($sformatf("row%0d_rst_held", idx), sample(), exp_t'(0));
    rst_n     = 1'b1;
    cur_level = 4'b0000;
    cur_req   = 2'd0;
  endtask

  initial begin
    // Test 1: press while held through reset, async clear, re-press, release
    add(OP_ROW, 4'b1111, 7,  4'b1111, 4'b1111, 4'b0000, 2'd3);
    add(OP_RST, 4'b1111, 0,  4'b0000, 4'b0000, 4'b0000, 2'd0);
    add(OP_ROW, 4'b1111, 7,  4'b1111, 4'b1111, 4'b0000, 2'd3);
    add(OP_ROW, 4'b0000, 7,  4'b0000, 4'b0000, 4'b1111, 2'd0);
    // Test 2: clean press on btn1, held 20 more cycles
    add(OP_ROW, 4'b0010, 26, 4'b0010, 4'b0010, 4'b0000, 2'd1);
    add(OP_ROW, 4'b0000, 7,  4'b0000, 4'b0000, 4'b0010, 2'd0);
    // Test 6: reset in the middle of a btn3 count, button still held
    add(OP_ROW, 4'b1000, 3,  4'b0000, 4'b0000, 4'b0000, 2'd0);
    add(OP_RST, 4'b1000, 0,  4'b0000, 4'b0000, 4'b0000, 2'd0);
    add(OP_ROW, 4'b1000, 8,  4'b1000, 4'b1000, 4'b0000, 2'd3);
    add(OP_ROW, 4'b0000, 7,  4'b0000, 4'b0000, 4'b1000, 2'd0);
    // Test 3: bounce on btn2, then hold
    add(OP_ROW, 4'b0100, 2,  4'b0000, 4'b0000, 4'b0000, 2'd0);
    add(OP_ROW, 4'b0000, 2,  4'b0000, 4'b0000, 4'b0000, 2'd0);
    add(OP_ROW, 4'b0100, 2,  4'b0000, 4'b0000, 4'b0000, 2'd0);
    add(OP_ROW, 4'b0000, 2,  4'b0000, 4'b0000, 4'b0000, 2'd0);
    add(OP_ROW, 4'b0100, 8,  4'b0100, 4'b0100, 4'b0000, 2'd2);
    add(OP_ROW, 4'b0000, 7,  4'b0000, 4'b0000, 4'b0100, 2'd0);
    // Test 4: simultaneous press / release
    add(OP_ROW, 4'b1101, 7,  4'b1101, 4'b1101, 4'b0000, 2'd3);
    add(OP_ROW, 4'b0000, 7,  4'b0000, 4'b0000, 4'b1101, 2'd0);
    // Test 5: 3-cycle glitch on btn0, then a real press proves the count restarted
    add(OP_ROW, 4'b0001, 3,  4'b0000, 4'b0000, 4'b0000, 2'd0);
    add(OP_ROW, 4'b0000, 8,  4'b0000, 4'b0000, 4'b0000, 2'd0);
    add(OP_ROW, 4'b0001, 7,  4'b0001, 4'b0001, 4'b0000, 2'd0);
    add(OP_ROW, 4'b0000, 7,  4'b0000, 4'b0000, 4'b0001, 2'd0);

    // Initial reset with all buttons asserted
    bus.btn_raw = 4'b1111;
    rst_n       = 1'b0;
    #3;
    cmp("init_rst", sample(), exp_t'(0));
    @(posedge clk_125);
    @(posedge clk_125);
    #1;
    cmp("init_rst_held", sample(), exp_t'(0));
    rst_n     = 1'b1;
    cur_level = 4'b0000;
    cur_req   = 2'd0;

    foreach (tbl[i]) begin
      if (tbl[i].op == OP_RST) run_rst(i);
      else                     run_row(i, tbl[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
